// File: rtl/fib_param_if.sv
// rtl/fib_param_if.sv - start/busy/done handshake bundle for the fib_param generator
// Purpose: groups the request inputs and the result outputs of fib_param.
// Signals:
//   start          request pulse, sampled by the engine while idle
//   i              term index, sampled with an accepted start
//   seed0, seed1   x(0) and x(1), sampled with an accepted start
//   busy           high while the engine is iterating
//   done           one-cycle pulse, result/overflow valid
//   result         x(i), held until the next done
//   overflow       x(i) did not fit in RES_W bits, held with result
// Modports: master drives requests (bench/host), slave is the engine.
interface fib_param_if #(
  parameter int IDX_W = 5,
  parameter int RES_W = 20
) ();
  logic             start;
  logic [IDX_W-1:0] i;
  logic [RES_W-1:0] seed0;
  logic [RES_W-1:0] seed1;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;
  logic             overflow;

  modport master (
    output start, i, seed0, seed1,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, i, seed0, seed1,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/fib_param.sv
// rtl/fib_param.sv - iterative generalised Fibonacci term generator
// Purpose: computes x(i) of x(0)=seed0, x(1)=seed1, x(n)=x(n-1)+x(n-2),
//   one addition per clock, with overflow detection.
// Ports:
//   clk    clock, all logic on the rising edge
//   rst    synchronous active-high reset
//   bus    fib_param_if.slave (start, i, seed0, seed1 in;
//          busy, done, result, overflow out)
// Build option: FIB_SAT_EN - when defined, an overflowed result is
//   replaced by all-ones; overflow is still reported.
module fib_param #(
  parameter int IDX_W = 5,
  parameter int RES_W = 20
) (
  input logic        clk,
  input logic        rst,
  fib_param_if.slave bus
);
  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t           r_state;
  logic [RES_W-1:0] r_a;
  logic [RES_W-1:0] r_b;
  logic [IDX_W-1:0] r_cnt;
  logic             r_ovf_a;
  logic             r_ovf_b;
  logic             r_busy;
  logic             r_done;
  logic [RES_W-1:0] r_result;
  logic             r_overflow;

  logic [RES_W:0]   w_sum;
  logic [RES_W-1:0] w_final;

  // One extra bit so the carry out of the wrapped sum is visible.
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

`ifdef FIB_SAT_EN
  assign w_final = r_ovf_a ? {RES_W{1'b1}} : r_a;
`else
  assign w_final = r_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_ovf_a    <= 1'b0;
      r_ovf_b    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.seed0;
            r_b     <= bus.seed1;
            r_cnt   <= bus.i;
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt != '0) begin
            // a tracks x(n), b tracks x(n+1); each carries its own
            // overflow flag so a wrap in the lookahead term b alone
            // never reaches the reported result.
            r_a     <= r_b;
            r_b     <= w_sum[RES_W-1:0];
            r_ovf_a <= r_ovf_b;
            r_ovf_b <= r_ovf_a | r_ovf_b | w_sum[RES_W];
            r_cnt   <= r_cnt - IDX_W'(1);
          end else begin
            r_result   <= w_final;
            r_overflow <= r_ovf_a;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_fib_param.sv
// tb/tb_fib_param.sv - self-checking bench for fib_param
module tb_fib_param;
  localparam int IDX_W = 5;
  localparam int RES_W = 20;
  localparam longint LIMIT = 64'd1 << RES_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fib_param_if #(.IDX_W(IDX_W), .RES_W(RES_W)) bus ();

  fib_param #(.IDX_W(IDX_W), .RES_W(RES_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: unbounded recurrence; the term overflows when its true
  // value does not fit in RES_W bits.
  task automatic model(input int idx, input longint s0, input longint s1,
                       output longint res, output logic ovf);
    longint x0, x1, t;
    x0 = s0;
    x1 = s1;
    for (int n = 0; n < idx; n++) begin
      t  = x0 + x1;
      x0 = x1;
      x1 = t;
    end
    ovf = (x0 >= LIMIT);
    res = x0 % LIMIT;
`ifdef FIB_SAT_EN
    if (ovf) res = LIMIT - 1;
`endif
  endtask

  task automatic launch(input string tag, input int idx, input longint s0, input longint s1);
    bus.start = 1'b1;
    bus.i     = IDX_W'(idx);
    bus.seed0 = RES_W'(s0);
    bus.seed1 = RES_W'(s1);
    step();
    bus.start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic run(input string tag, input int idx, input longint s0, input longint s1,
                     input longint exp_res, input logic exp_ovf);
    int n;
    launch(tag, idx, s0, s1);
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'(idx + 1));
    chk({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'(exp_ovf));
    chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    step();
    chk({tag, "_done_width"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int     n;
    int     cyc;
    int     dcount;
    int     idx;
    longint s0, s1, mres;
    logic   movf;

    bus.start = 1'b0;
    bus.i     = '0;
    bus.seed0 = '0;
    bus.seed1 = '0;

    // Reset held for 10 cycles.
    rst = 1'b1;
    repeat (10) step();
    rst = 1'b0;
    step();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    dcount = 0;
    repeat (10) begin
      step();
      if (bus.done === 1'b1) dcount++;
    end
    chk("idle_no_done", 64'(dcount), 64'd0);

    // Plain Fibonacci.
    run("fib_i0", 0, 0, 1, 0, 1'b0);
    run("fib_i1", 1, 0, 1, 1, 1'b0);
    run("fib_i2", 2, 0, 1, 1, 1'b0);
    run("fib_i10", 10, 0, 1, 55, 1'b0);

    // Lucas, then the largest term that still fits.
    run("lucas_i10", 10, 2, 1, 123, 1'b0);
    run("fib_i30", 30, 0, 1, 832040, 1'b0);

    // Maximum index overflows RES_W=20.
`ifdef FIB_SAT_EN
    run("fib_i31", 31, 0, 1, 1048575, 1'b1);
`else
    run("fib_i31", 31, 0, 1, 297693, 1'b1);
`endif

    // start while busy is ignored.
    launch("ign", 20, 0, 1);
    cyc = 0;
    repeat (4) begin
      step();
      cyc++;
    end
    bus.start = 1'b1;
    bus.i     = IDX_W'(3);
    step();
    cyc++;
    bus.start = 1'b0;
    wait_done(n);
    chk("ign_latency", 64'(cyc + n), 64'd21);
    chk("ign_result", 64'(bus.result), 64'd6765);

    // start in the done cycle is accepted.
    bus.start = 1'b1;
    bus.i     = IDX_W'(5);
    bus.seed0 = '0;
    bus.seed1 = RES_W'(1);
    step();
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    chk("b2b_latency", 64'(n), 64'd6);
    chk("b2b_result", 64'(bus.result), 64'd5);
    step();
    chk("b2b_done_width", 64'(bus.done), 64'd0);

    // Reset mid-computation aborts the request.
    launch("abort", 25, 0, 1);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_overflow", 64'(bus.overflow), 64'd0);
    dcount = 0;
    repeat (40) begin
      step();
      if (bus.done === 1'b1) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    run("after_abort_i7", 7, 0, 1, 13, 1'b0);

    // Random seeds and indices against the reference recurrence.
    for (int k = 0; k < 24; k++) begin
      idx = int'($urandom_range(0, (1 << IDX_W) - 1));
      if (k % 2 == 0) begin
        s0 = longint'($urandom_range(0, 15));
        s1 = longint'($urandom_range(0, 15));
      end else begin
        s0 = longint'($urandom_range(0, (1 << RES_W) - 1));
        s1 = longint'($urandom_range(0, (1 << RES_W) - 1));
      end
      model(idx, s0, s1, mres, movf);
      run("rand", idx, s0, s1, mres, movf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
